// File: rtl/psd_sqrt_pkg.sv
// Shared types and width helpers for the bit-serial square-root unit.
package psd_sqrt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int root_w(input int xin_w, input int frac_bits);
        return xin_w / 2 + frac_bits;
    endfunction

    function automatic int rem_w(input int xin_w, input int frac_bits);
        return root_w(xin_w, frac_bits) + 1;
    endfunction

    function automatic bit xin_w_ok(input int xin_w);
        return (xin_w >= 2) && ((xin_w % 2) == 0);
    endfunction

endpackage

// File: rtl/psd_sqrt_step.sv
// One restoring square-root iteration: consumes two operand bits, yields one root bit.
module psd_sqrt_step #(
    parameter  int OUT_W = 16,
    localparam int REM_W = OUT_W + 1
) (
    input  logic [REM_W-1:0] rem_p,
    input  logic [OUT_W-1:0] root_p,
    input  logic [1:0]       bits,
    output logic [REM_W-1:0] rem_n,
    output logic [OUT_W-1:0] root_n
);

    logic [REM_W+1:0] trial;
    logic [REM_W+1:0] test;
    logic [REM_W-1:0] diff;
    logic             ge;

    assign trial = {rem_p, bits};
    assign test  = {1'b0, root_p, 2'b01};
    assign ge    = (trial >= test);
    // When ge holds the difference fits in REM_W bits, so the low slice is exact.
    assign diff  = trial[REM_W-1:0] - test[REM_W-1:0];
    assign rem_n = ge ? diff : trial[REM_W-1:0];

    if (OUT_W > 1) begin : g_wide
        assign root_n = {root_p[OUT_W-2:0], ge};
    end else begin : g_single
        assign root_n = ge;
    end

endmodule

// File: rtl/psd_sqrt_seq.sv
// Bit-serial integer square root: floor(sqrt(xin * 4^FRAC_BITS)) plus exact remainder.
module psd_sqrt_seq
    import psd_sqrt_pkg::*;
#(
    parameter  int XIN_W     = 32,
    parameter  int FRAC_BITS = 0,
    localparam int OUT_W     = root_w(XIN_W, FRAC_BITS),
    localparam int REM_W     = rem_w(XIN_W, FRAC_BITS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [XIN_W-1:0] xin,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] sqrt,
    output logic [REM_W-1:0] rem
);

    localparam int OPND_W = 2 * OUT_W;
    localparam int CNT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OUT_W - 1);

    if (!xin_w_ok(XIN_W)) begin : g_bad_width
        $error("psd_sqrt_seq: XIN_W must be even and at least 2");
    end

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OPND_W-1:0] opnd_q;
    logic [OPND_W-1:0] opnd_init;
    logic [REM_W-1:0]  rem_p_q;
    logic [OUT_W-1:0]  root_p_q;
    logic [REM_W-1:0]  rem_d;
    logic [OUT_W-1:0]  root_d;
    logic [OUT_W-1:0]  sqrt_q;
    logic [REM_W-1:0]  rem_q;
    logic              busy_q;
    logic              done_q;

    assign opnd_init = OPND_W'(xin) << (2 * FRAC_BITS);

    psd_sqrt_step #(.OUT_W(OUT_W)) u_step (
        .rem_p  (rem_p_q),
        .root_p (root_p_q),
        .bits   (opnd_q[OPND_W-1 -: 2]),
        .rem_n  (rem_d),
        .root_n (root_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            rem_p_q  <= '0;
            root_p_q <= '0;
            sqrt_q   <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == RUN) begin
                rem_p_q  <= rem_d;
                root_p_q <= root_d;
                opnd_q   <= opnd_q << 2;
                if (cnt_q == '0) begin
                    sqrt_q  <= root_d;
                    rem_q   <= rem_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
            // A start restarts the iteration even mid-run; the final result above still lands.
            if (start) begin
                state_q  <= RUN;
                busy_q   <= 1'b1;
                opnd_q   <= opnd_init;
                rem_p_q  <= '0;
                root_p_q <= '0;
                cnt_q    <= CNT_INIT;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sqrt = sqrt_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_psd_sqrt_seq.sv
// Bench for psd_sqrt_seq: directed corner cases plus randomized run against an isqrt model.
module tb_psd_sqrt_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] xin0, xin1;
    logic        busy0, done0, busy1, done1;
    logic [15:0] sqrt0;
    logic [16:0] rem0;
    logic [23:0] sqrt1;
    logic [24:0] rem1;

    int n_chk = 0;
    int n_err = 0;
    int dcnt0 = 0;
    int dcnt1 = 0;
    int wid_err = 0;
    bit pd0 = 1'b0;
    bit pd1 = 1'b0;

    always #5 clock = ~clock;

    psd_sqrt_seq #(.XIN_W(32), .FRAC_BITS(0)) dut0 (
        .clock (clock), .reset (reset), .start (start0), .xin (xin0),
        .busy (busy0), .done (done0), .sqrt (sqrt0), .rem (rem0)
    );

    psd_sqrt_seq #(.XIN_W(32), .FRAC_BITS(8)) dut1 (
        .clock (clock), .reset (reset), .start (start1), .xin (xin1),
        .busy (busy1), .done (done1), .sqrt (sqrt1), .rem (rem1)
    );

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned r;
        r = longint'($rtoi($sqrt(real'(v))));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    always @(posedge clock) begin
        #1;
        if (done0) begin
            dcnt0++;
            if (pd0) wid_err++;
        end
        if (done1) begin
            dcnt1++;
            if (pd1) wid_err++;
        end
        pd0 = done0;
        pd1 = done1;
    end

    task automatic run_op(input bit sel, input logic [31:0] x,
                          input longint unsigned es, input longint unsigned er, input int elat);
        longint unsigned held;
        int cyc, bc;
        bit hold_ok, dn;
        held = sel ? sqrt1 : sqrt0;
        if (sel) begin start1 = 1'b1; xin1 = x; end
        else     begin start0 = 1'b1; xin0 = x; end
        @(posedge clock); #1;
        start0 = 1'b0; start1 = 1'b0;
        xin0 = $urandom; xin1 = $urandom;
        cyc = 0;
        hold_ok = 1'b1;
        bc = (sel ? busy1 : busy0) ? 1 : 0;
        dn = 1'b0;
        while (!dn && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            dn = sel ? done1 : done0;
            if (sel ? busy1 : busy0) bc++;
            if (!dn && (sel ? longint'(sqrt1) : longint'(sqrt0)) != held) hold_ok = 1'b0;
        end
        check_eq("latency", cyc, elat);
        check_eq("busy_cycles", bc, elat);
        check_eq("sqrt", sel ? sqrt1 : sqrt0, es);
        check_eq("rem", sel ? rem1 : rem0, er);
        check_eq("hold_prev", hold_ok, 1);
        @(posedge clock); #1;
        check_eq("done_one_cycle", sel ? done1 : done0, 0);
    endtask

    initial begin
        int d_before;
        int c, gap, ops, due;
        bit pend_v, st_next;
        longint unsigned pend_x, nx, s, r, t;

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; xin0 = '0; xin1 = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_sqrt", sqrt0, 0);
        check_eq("rst_rem", rem0, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op(0, 32'd0, 0, 0, 16);
        run_op(0, 32'd99, 9, 18, 16);
        run_op(0, 32'd1000000, 1000, 0, 16);
        run_op(0, 32'hFFFF_FFFF, 64'hFFFF, 64'h1FFFE, 16);
        run_op(1, 32'd2, 362, 28, 24);

        // Restart 5 cycles into a computation: only the second operand completes.
        d_before = dcnt0;
        start0 = 1'b1; xin0 = 32'd99;
        @(posedge clock); #1;
        start0 = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        run_op(0, 32'd144, 12, 0, 16);
        check_eq("abort_done_count", dcnt0 - d_before, 1);

        // Reset mid-computation.
        start0 = 1'b1; xin0 = 32'd99;
        @(posedge clock); #1;
        start0 = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("mid_rst_busy", busy0, 0);
        check_eq("mid_rst_done", done0, 0);
        check_eq("mid_rst_sqrt", sqrt0, 0);
        check_eq("mid_rst_rem", rem0, 0);
        reset = 1'b0;
        d_before = dcnt0;
        repeat (20) @(posedge clock);
        #1;
        check_eq("no_done_after_rst", dcnt0 - d_before, 0);
        run_op(0, 32'd49, 7, 0, 16);

        // Randomized operands and start spacing, including restarts and back-to-back starts.
        c = 0; gap = 0; ops = 0; due = 0;
        pend_v = 1'b0; st_next = 1'b0; pend_x = 0; nx = 0;
        while ((ops < 2500 || pend_v || st_next) && c < 80000) begin
            if (pend_v && due == c) begin
                s = sqrt0; r = rem0;
                check_eq("rnd_done", done0, 1);
                check_eq("rnd_sqrt", s, isqrt(pend_x));
                check_eq("rnd_rem", r, pend_x - isqrt(pend_x) * isqrt(pend_x));
                check_eq("rnd_identity", s * s + r, pend_x);
                check_eq("rnd_rem_bound", r <= 2 * s, 1);
                pend_v = 1'b0;
            end else begin
                check_eq("rnd_no_done", done0, 0);
            end
            if (st_next) begin
                pend_v = 1'b1;
                pend_x = nx;
                due = c + 16;
            end
            check_eq("rnd_busy", busy0, pend_v);
            start0 = 1'b0;
            st_next = 1'b0;
            if (ops < 2500 && gap == 0) begin
                case ($urandom_range(0, 3))
                    0: nx = $urandom;
                    1: nx = $urandom_range(0, 300);
                    2: begin t = $urandom_range(0, 65535); nx = t * t; end
                    default: nx = 32'hFFFF_FFFF - $urandom_range(0, 1000);
                endcase
                start0 = 1'b1;
                xin0 = nx[31:0];
                st_next = 1'b1;
                ops++;
                gap = $urandom_range(0, 23);
            end else begin
                if (gap > 0) gap--;
                xin0 = $urandom;
            end
            @(posedge clock); #1;
            c++;
        end
        start0 = 1'b0;
        check_eq("rnd_timeout", c < 80000, 1);
        check_eq("done_width_all", wid_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
